// File: rtl/gb_cpu_bus_target.sv
// Bus responder for the LR35902 strobe bus: turns each CPU memory access into one
// request/acknowledge backend transaction, stalling the CPU with WAIT_n until it completes.
module gb_cpu_bus_target #(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] OPEN_BUS       = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_di,
    output logic        cpu_wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err,
    input  logic        err_clr
);

    // state     | meaning
    // ST_IDLE   | no access in flight, watching the CPU strobes
    // ST_ACCESS | backend request outstanding, CPU stalled, timer running
    // ST_DONE   | access finished, data held until the CPU releases its strobes
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_cpu_di;
    logic        r_cpu_wait_n;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_timeout_err;

    logic w_acc;
    logic w_strobes_idle;
    logic w_timeout;

    // Both strobes low is not a valid access, so only exactly one of them may be asserted.
    assign w_acc          = !cpu_mreq_n && cpu_iorq_n && (cpu_rd_n != cpu_wr_n);
    assign w_strobes_idle = cpu_rd_n && cpu_wr_n;
    assign w_timeout      = (r_state == ST_ACCESS) && !mem_ack && (r_timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= 16'd0;
            r_cpu_di      <= 8'hFF;
            r_cpu_wait_n  <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_mem_wdata   <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_mem_addr   <= cpu_a;
                        r_mem_we     <= !cpu_wr_n;
                        r_mem_wdata  <= cpu_do;
                        r_mem_req    <= 1'b1;
                        r_cpu_wait_n <= 1'b0;
                        r_timer      <= 16'd0;
                        r_state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // Data and wait release share an edge so the CPU latches valid data.
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_cpu_wait_n <= 1'b1;
                        if (!r_mem_we) begin
                            r_cpu_di <= mem_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_mem_req    <= 1'b0;
                        r_cpu_wait_n <= 1'b1;
                        if (!r_mem_we) begin
                            r_cpu_di <= OPEN_BUS;
                        end
                        r_state <= ST_DONE;
                    end else if (r_timer != 16'hFFFF) begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                ST_DONE: begin
                    if (w_strobes_idle) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_di      = r_cpu_di;
    assign cpu_wait_n  = r_cpu_wait_n;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gb_cpu_bus_target.sv
// Self-checking bench: two instances (long and short timeout) share the CPU bus and backend
// ack; a transaction-level model predicts wait length, read data, request count and error flag.
module tb_gb_cpu_bus_target;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic        mem_ack, err_clr;
    logic [7:0]  mem_rdata;

    logic [7:0]  di0, di1, wd0, wd1;
    logic [15:0] addr0, addr1;
    logic        wait0, wait1, req0, req1, we0, we1, err0, err1;

    gb_cpu_bus_target #(.TIMEOUT_CYCLES(255), .OPEN_BUS(8'hFF)) u_dut0 (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_di(di0), .cpu_wait_n(wait0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wd0), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(err0),
        .err_clr(err_clr));

    gb_cpu_bus_target #(.TIMEOUT_CYCLES(4), .OPEN_BUS(8'hFF)) u_dut1 (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_di(di1), .cpu_wait_n(wait1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(err1),
        .err_clr(err_clr));

    logic [7:0]  o_di   [2];
    logic [7:0]  o_wd   [2];
    logic [15:0] o_addr [2];
    logic        o_wait [2];
    logic        o_req  [2];
    logic        o_we   [2];
    logic        o_err  [2];
    assign o_di[0] = di0;     assign o_di[1] = di1;
    assign o_wd[0] = wd0;     assign o_wd[1] = wd1;
    assign o_addr[0] = addr0; assign o_addr[1] = addr1;
    assign o_wait[0] = wait0; assign o_wait[1] = wait1;
    assign o_req[0] = req0;   assign o_req[1] = req1;
    assign o_we[0] = we0;     assign o_we[1] = we1;
    assign o_err[0] = err0;   assign o_err[1] = err1;

    // Rising edges of mem_req, counted independently of the sampling tasks.
    logic [1:0] req_d = 2'b00;
    int         nreq0 = 0;
    int         nreq1 = 0;
    always @(posedge clk) begin
        req_d <= {req1, req0};
        if (req0 && !req_d[0]) nreq0 <= nreq0 + 1;
        if (req1 && !req_d[1]) nreq1 <= nreq1 + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cur_vec  = 0;

    int          to_cycles [2] = '{255, 4};
    logic [7:0]  exp_di    [2];
    logic        exp_err   [2];
    int          exp_nreq  [2];
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d vec%0d actual=%0h required=%0h", name, i, cur_vec, act, req);
        end
    endtask

    task automatic chk_held(input int i);
        chk("cpu_di", i, 32'(o_di[i]), 32'(exp_di[i]));
        chk("timeout_err", i, 32'(o_err[i]), 32'(exp_err[i]));
        chk("mem_addr", i, 32'(o_addr[i]), 32'(exp_addr));
        chk("mem_we", i, 32'(o_we[i]), 32'(exp_we));
        chk("mem_wdata", i, 32'(o_wd[i]), 32'(exp_wdata));
    endtask

    task automatic chk_idle_all();
        for (int i = 0; i < 2; i++) begin
            chk("wait_n_idle", i, 32'(o_wait[i]), 32'd1);
            chk("mem_req_idle", i, 32'(o_req[i]), 32'd0);
            chk_held(i);
        end
    endtask

    task automatic chk_nreq();
        chk("req_count", 0, 32'(nreq0), 32'(exp_nreq[0]));
        chk("req_count", 1, 32'(nreq1), 32'(exp_nreq[1]));
    endtask

    task automatic release_bus();
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_iorq_n = 1'b1;
        mem_ack = 1'b0; err_clr = 1'b0;
    endtask

    // One CPU access; rk0/rk1 are the expected wait-low lengths in clocks for each instance.
    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                             input logic [7:0] do_after, input int d, input logic ack_en,
                             input logic [7:0] rd, input logic clr, input int rk0, input int rk1);
        int   rk [2];
        logic tout [2];
        int   kmax;
        rk[0] = rk0; rk[1] = rk1;
        for (int i = 0; i < 2; i++) tout[i] = !(ack_en && rk[i] == d + 1);
        kmax = ((rk[0] > rk[1]) ? rk[0] : rk[1]) + 2;

        @(negedge clk);
        cpu_a = addr; cpu_do = wd; cpu_mreq_n = 1'b0; cpu_iorq_n = 1'b1;
        cpu_rd_n = wr; cpu_wr_n = !wr; err_clr = clr; mem_ack = 1'b0;
        @(posedge clk); #1;
        exp_addr = addr; exp_we = wr; exp_wdata = wd;
        for (int i = 0; i < 2; i++) begin
            exp_nreq[i]++;
            if (clr) exp_err[i] = 1'b0;
            chk("req_start", i, 32'(o_req[i]), 32'd1);
            chk("wait_start", i, 32'(o_wait[i]), 32'd0);
            chk_held(i);
        end
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            cpu_do = do_after;
            mem_ack = ack_en && (k - 1 == d);
            mem_rdata = mem_ack ? rd : 8'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (k == rk[i]) begin
                    if (tout[i]) exp_err[i] = 1'b1;
                    else if (clr) exp_err[i] = 1'b0;
                    if (!wr) exp_di[i] = tout[i] ? 8'hFF : rd;
                end else if (clr) begin
                    exp_err[i] = 1'b0;
                end
                chk("wait_n", i, 32'(o_wait[i]), 32'(k >= rk[i]));
                chk("mem_req", i, 32'(o_req[i]), 32'(k < rk[i]));
                chk_held(i);
            end
        end
        @(negedge clk);
        release_bus();
        @(posedge clk); #1;
        chk_idle_all();
        chk_nreq();
    endtask

    task automatic do_ignored(input logic iorq_case);
        @(negedge clk);
        cpu_a = 16'($urandom); cpu_do = 8'($urandom); cpu_mreq_n = 1'b0;
        if (iorq_case) begin
            cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        end else begin
            cpu_iorq_n = 1'b1; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_idle_all();
        end
        @(negedge clk);
        release_bus();
        @(posedge clk); #1;
        chk_idle_all();
        chk_nreq();
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          d;
        logic        ack_en;
        logic        clr;
        int          low0;
        int          low1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 16'hC123, 8'h00, 8'h5A, 2, 1'b1, 1'b0, 3, 3};
        tbl[1] = '{1'b1, 16'h8000, 8'h3C, 8'h00, 4, 1'b1, 1'b0, 5, 4};
        tbl[2] = '{1'b0, 16'h1234, 8'h00, 8'h01, 0, 1'b1, 1'b0, 1, 1};
        tbl[3] = '{1'b0, 16'h1235, 8'h00, 8'hA5, 1, 1'b1, 1'b0, 2, 2};
        tbl[4] = '{1'b0, 16'h4000, 8'h00, 8'h77, 6, 1'b1, 1'b0, 7, 4};
        tbl[5] = '{1'b1, 16'h9000, 8'h55, 8'h00, 3, 1'b1, 1'b1, 4, 4};
        tbl[6] = '{1'b0, 16'h4001, 8'h00, 8'hC3, 5, 1'b1, 1'b1, 6, 4};
        tbl[7] = '{1'b0, 16'h0000, 8'h00, 8'h00, 0, 1'b0, 1'b0, 255, 4};

        reset = 1'b1;
        cpu_a = 16'h0; cpu_do = 8'h0; mem_rdata = 8'h0;
        release_bus();
        for (int i = 0; i < 2; i++) begin
            exp_di[i] = 8'hFF; exp_err[i] = 1'b0; exp_nreq[i] = 0;
        end
        exp_addr = 16'h0; exp_we = 1'b0; exp_wdata = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_all();
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            cur_vec = v;
            do_access(tbl[v].wr, tbl[v].addr, tbl[v].wd, 8'hFF, tbl[v].d, tbl[v].ack_en,
                      tbl[v].rd, tbl[v].clr, tbl[v].low0, tbl[v].low1);
        end

        cur_vec = 100;
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        chk_idle_all();
        @(negedge clk);
        err_clr = 1'b0;

        cur_vec = 101;
        do_ignored(1'b1);
        cur_vec = 102;
        do_ignored(1'b0);

        // Reset two clocks into a read, then a stray ack after reset.
        cur_vec = 103;
        @(negedge clk);
        cpu_a = 16'h2222; cpu_mreq_n = 1'b0; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        @(posedge clk); #1;
        exp_nreq[0]++; exp_nreq[1]++;
        chk("req_start", 0, 32'(req0), 32'd1);
        chk("req_start", 1, 32'(req1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        release_bus();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            exp_di[i] = 8'hFF; exp_err[i] = 1'b0;
        end
        exp_addr = 16'h0; exp_we = 1'b0; exp_wdata = 8'h0;
        chk_idle_all();
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
        @(posedge clk); #1;
        chk_idle_all();
        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk); #1;
        chk_idle_all();
        chk_nreq();

        for (int v = 0; v < 40; v++) begin
            logic       r_wr, r_clr;
            int         r_d;
            int         rk [2];
            cur_vec = 200 + v;
            if ($urandom_range(0, 5) == 0) do_ignored(1'($urandom_range(0, 1)));
            r_wr  = 1'($urandom_range(0, 1));
            r_clr = ($urandom_range(0, 3) == 0);
            r_d   = int'($urandom_range(0, 7));
            for (int i = 0; i < 2; i++) rk[i] = (r_d + 1 <= to_cycles[i]) ? r_d + 1 : to_cycles[i];
            do_access(r_wr, 16'($urandom), 8'($urandom), 8'($urandom), r_d, 1'b1,
                      8'($urandom), r_clr, rk[0], rk[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
